// File: rtl/rf_port_sched.sv
// rtl/rf_port_sched.sv - single-port RF scheduler: serialised rs1/rs2 fetch with writeback priority
// Optional x0 read skipping when RF_PORT_SCHED_X0_SKIP_EN is defined.
module rf_port_sched #(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(REG_COUNT)-1:0] req_rs1,
  input  logic [$clog2(REG_COUNT)-1:0] req_rs2,
  input  logic                         req_need_rs2,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WORD_SIZE-1:0]         op1,
  output logic [WORD_SIZE-1:0]         op2,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [$clog2(REG_COUNT)-1:0] wb_addr,
  input  logic [WORD_SIZE-1:0]         wb_data,
  output logic                         rf_we,
  output logic [$clog2(REG_COUNT)-1:0] rf_addr,
  output logic [WORD_SIZE-1:0]         rf_wdata,
  input  logic [WORD_SIZE-1:0]         rf_rdata
);

  localparam int AW = $clog2(REG_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t               state_q;
  logic [AW-1:0]        rs1_q;
  logic [AW-1:0]        rs2_q;
  logic                 need2_q;
  logic [WORD_SIZE-1:0] op1_q;
  logic [WORD_SIZE-1:0] op2_q;
  logic                 rsp_valid_q;
  logic                 req_fire;
  logic                 rd2_needed;

  assign req_fire = (state_q == IDLE) & req_valid & ~wb_valid;

`ifdef RF_PORT_SCHED_X0_SKIP_EN
  assign rd2_needed = need2_q & (rs2_q != '0);
`else
  assign rd2_needed = need2_q;
`endif

  // Writeback only ever owns the port in IDLE; x0 writes are consumed but never reach the rf.
  always_comb begin
    wb_ready  = 1'b0;
    req_ready = 1'b0;
    rf_we     = 1'b0;
    rf_addr   = '0;
    rf_wdata  = '0;
    case (state_q)
      IDLE: begin
        wb_ready  = 1'b1;
        req_ready = ~wb_valid;
        rf_addr   = wb_addr;
        rf_wdata  = wb_data;
        rf_we     = rstn & wb_valid & (wb_addr != '0);
      end
      RD1:     rf_addr = rs1_q;
      RD2:     rf_addr = rs2_q;
      default: rf_addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      need2_q     <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            rs1_q   <= req_rs1;
            rs2_q   <= req_rs2;
            need2_q <= req_need_rs2;
`ifdef RF_PORT_SCHED_X0_SKIP_EN
            // Skipped x0 reads leave their operand at the zero loaded here.
            op1_q <= '0;
            op2_q <= '0;
            if (req_rs1 != '0) begin
              state_q <= RD1;
            end else if (req_need_rs2 && (req_rs2 != '0)) begin
              state_q <= RD2;
            end else begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
            end
`else
            state_q <= RD1;
`endif
          end
        end
        RD1: begin
          op1_q <= rf_rdata;
          if (rd2_needed) begin
            state_q <= RD2;
          end else begin
            op2_q       <= '0;
            state_q     <= RSP;
            rsp_valid_q <= 1'b1;
          end
        end
        RD2: begin
          op2_q       <= rf_rdata;
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
        end
        RSP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign op1       = op1_q;
  assign op2       = op2_q;
  assign rsp_valid = rsp_valid_q;

endmodule
